// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: initiator side of the ALU operand interface.
// Accepts commands (cmd_*) over valid/ready and drives alu_a/alu_b/alu_sel.
// Arithmetic and logic ops are held for SETTLE cycles and then sampled from alu_out/alu_ovf.
// The two shift ops run locally, one bit per cycle.
// Results are queued in a RSP_DEPTH-entry FIFO that is drained over rsp_valid/rsp_ready
// (rsp_data/rsp_ovf/rsp_op).
// busy is high outside IDLE.
// stat_ops/stat_ovf count pushes and overflow pushes when DRIVER_STATS_EN is defined.
// Otherwise they read 0.
// Optional feature macro: DRIVER_STATS_EN.
module alu_cmd_driver #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic [2:0]       rsp_op,
    output logic             busy,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_ovf
);

    localparam int unsigned AW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned CNTW = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SHIFT} state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [WIDTH-1:0]  sr;
    logic              st;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  mem_data [RSP_DEPTH];
    logic              mem_ovf  [RSP_DEPTH];
    logic [2:0]        mem_op   [RSP_DEPTH];

    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  push_data;
    logic              push_ovf;
    logic              accept;

    assign cmd_ready = (state == ST_IDLE) && (count < CW'(RSP_DEPTH)) && clear_n;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE);

    // Result selection at the completion edge; alu_sel still holds the latched op.
    always_comb begin
        push      = 1'b0;
        push_data = sr;
        push_ovf  = st;
        case (state)
            ST_SETTLE: begin
                push      = (cnt == '0);
                push_data = alu_out;
                // ALU overflow is only defined for add
                push_ovf  = (alu_sel == 3'b000) && alu_ovf;
            end
            ST_SHIFT: push = (cnt == '0);
            default:  push = 1'b0;
        endcase
    end

    // Command FSM and registered ALU drive
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sr      <= '0;
            st      <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= 3'b000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a   <= cmd_a;
                        alu_b   <= cmd_b;
                        alu_sel <= cmd_op;
                        if (cmd_op[2:1] == 2'b11) begin
                            state <= ST_SHIFT;
                            cnt   <= {1'b0, cmd_b[2:0]};
                            sr    <= cmd_a;
                            st    <= 1'b0;
                        end else begin
                            state <= ST_SETTLE;
                            cnt   <= CNTW'(SETTLE - 1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt != '0) cnt <= cnt - CNTW'(1);
                    else           state <= ST_IDLE;
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNTW'(1);
                        // st collects every bit shifted out
                        if (alu_sel == 3'b110) begin
                            sr <= {sr[WIDTH-2:0], 1'b0};
                            st <= st | sr[WIDTH-1];
                        end else begin
                            sr <= {1'b0, sr[WIDTH-1:1]};
                            st <= st | sr[0];
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result FIFO pointers and occupancy
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by count so need no reset
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_ovf[wr_ptr]  <= push_ovf;
            mem_op[wr_ptr]   <= alu_sel;
        end
    end

    assign rsp_data = mem_data[rd_ptr];
    assign rsp_ovf  = mem_ovf[rd_ptr];
    assign rsp_op   = mem_op[rd_ptr];

`ifdef DRIVER_STATS_EN
    // Saturating push / overflow counters
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (push) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (push_ovf && (stat_ovf != 16'hFFFF)) stat_ovf <= stat_ovf + 16'd1;
        end
    end
`else
    assign stat_ops = '0;
    assign stat_ovf = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver (WIDTH=8, SETTLE=1, RSP_DEPTH=4).
// Uses a behavioural ALU, a queue-based reference model and a pop monitor.
module tb_alu_cmd_driver;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       alu_ovf;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_ovf;
    logic [2:0] rsp_op;
    logic       busy;
    logic [15:0] stat_ops, stat_ovf;

    int tests = 0;
    int fails = 0;

    logic       ovr_en = 1'b0;
    logic [7:0] ovr_out = 8'h00;
    logic       ovr_ovf = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
        logic [2:0] op;
    } rsp_t;

    rsp_t exp_q[$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       oe;
        logic [7:0] oo;
        logic       ov;
        logic [7:0] ed;
        logic       eo;
        int         lat;
    } vec_t;

    alu_cmd_driver #(.WIDTH(8), .SETTLE(1), .RSP_DEPTH(4)) dut (
        .clock(clock), .clear_n(clear_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .rsp_op(rsp_op), .busy(busy),
        .stat_ops(stat_ops), .stat_ovf(stat_ovf)
    );

    always #5 clock = ~clock;

    // Behavioural ALU. Overflow is driven high for non-add ops, so masking is visible.
    function automatic logic [8:0] alu_fn(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b1, a - b};
            3'd2:    return {1'b1, a & b};
            3'd3:    return {1'b1, a | b};
            3'd4:    return {1'b1, a ^ b};
            3'd5:    return {1'b1, ~a};
            default: return {1'b1, 8'h5A};
        endcase
    endfunction

    assign {alu_ovf, alu_out} = ovr_en ? {ovr_ovf, ovr_out} : alu_fn(alu_sel, alu_a, alu_b);

    // Expected result. Shifts are whole-word shifts and the flag is the OR of the lost bits.
    function automatic rsp_t ref_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        rsp_t        r;
        logic [8:0]  v;
        logic [15:0] f;
        r.op = op;
        if (op == 3'd6) begin
            f = {8'h00, a} << b[2:0];
            r.data = f[7:0];
            r.ovf  = |f[15:8];
        end else if (op == 3'd7) begin
            f = {a, 8'h00} >> b[2:0];
            r.data = f[15:8];
            r.ovf  = |f[7:0];
        end else begin
            v = ovr_en ? {ovr_ovf, ovr_out} : alu_fn(op, a, b);
            r.data = v[7:0];
            r.ovf  = (op == 3'd0) && v[8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present a command. Returns 1ns after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int budget;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        if (!cmd_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        exp_q.push_back(ref_fn(op, a, b));
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    // Every pop is compared against the reference queue.
    always @(negedge clock) begin
        rsp_t e;
        if (clear_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
                check("rsp_op", 32'(rsp_op), 32'(e.op));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vt[5];
        int         lat;
        int         n;
        int         g;
        logic       seen;
        logic [7:0] a5, b5;
        rsp_t       hd;

        vt[0] = '{3'd0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1};
        vt[1] = '{3'd6, 8'hA1, 8'd3,  1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 4};
        vt[2] = '{3'd7, 8'h0F, 8'd2,  1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 3};
        vt[3] = '{3'd7, 8'hF0, 8'd0,  1'b0, 8'h00, 1'b0, 8'hF0, 1'b0, 1};
        vt[4] = '{3'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1};

        // Reset state
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_alu_sel", 32'(alu_sel), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        #1 check("post_rst_cmd_ready", 32'(cmd_ready), 1);

        // Directed vectors with latency checks
        for (int i = 0; i < 5; i++) begin
            ovr_en = vt[i].oe; ovr_out = vt[i].oo; ovr_ovf = vt[i].ov;
            send(vt[i].op, vt[i].a, vt[i].b);
            check("busy_after_accept", 32'(busy), 1);
            check("ready_low_after_accept", 32'(cmd_ready), 0);
            lat = 0;
            do begin
                @(posedge clock); #1;
                lat++;
            end while (!rsp_valid && lat < 30);
            check("vec_latency", 32'(lat), 32'(vt[i].lat));
            check("vec_data", 32'(rsp_data), 32'(vt[i].ed));
            check("vec_ovf", 32'(rsp_ovf), 32'(vt[i].eo));
            check("vec_op", 32'(rsp_op), 32'(vt[i].op));
            rsp_ready = 1'b1;
            @(posedge clock); #1 rsp_ready = 1'b0;
            check("vec_popped", 32'(rsp_valid), 0);
            ovr_en = 1'b0;
            if (i == 3) begin
`ifdef DRIVER_STATS_EN
                check("stat_ops", 32'(stat_ops), 4);
                check("stat_ovf", 32'(stat_ovf), 3);
`else
                check("stat_ops", 32'(stat_ops), 0);
                check("stat_ovf", 32'(stat_ovf), 0);
`endif
            end
        end

        // Reset in the middle of a 7-bit shift
        send(3'd6, 8'hA5, 8'd7);
        repeat (3) @(posedge clock);
        #1 clear_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_alu_sel", 32'(alu_sel), 0);
        check("midrst_cmd_ready", 32'(cmd_ready), 0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock); #1;
        check("midrst_ready_after", 32'(cmd_ready), 1);
        check("midrst_stats", 32'(stat_ops), 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (rsp_valid) seen = 1'b1;
        end
        check("midrst_no_result", 32'(seen), 0);

        // Backpressure: four results fill the FIFO and the fifth command is held
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd2, 8'($urandom), 8'($urandom));
        repeat (2) @(negedge clock);
        check("full_cmd_ready", 32'(cmd_ready), 0);
        a5 = 8'($urandom); b5 = 8'($urandom);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = a5; cmd_b = b5;
        repeat (3) @(negedge clock);
        check("fifth_held_ready", 32'(cmd_ready), 0);
        check("fifth_held_busy", 32'(busy), 0);
        @(posedge clock); #1 rsp_ready = 1'b1;
        @(posedge clock); #1 rsp_ready = 1'b0;
        @(negedge clock);
        check("fifth_ready_after_pop", 32'(cmd_ready), 1);
        if (cmd_ready) exp_q.push_back(ref_fn(3'd2, a5, b5));
        @(posedge clock); #1 cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || rsp_valid) && g < 40) begin
            @(posedge clock); #1;
            g++;
        end
        rsp_ready = 1'b0;
        check("bp_drained", 32'(exp_q.size()), 0);

        // Push and pop on the same edge with three entries queued
        for (int i = 0; i < 3; i++) send(3'd4, 8'($urandom), 8'($urandom));
        @(posedge clock); #1;
        send(3'd3, 8'h3C, 8'h81);
        rsp_ready = 1'b1;
        hd = exp_q[0];
        check("simul_head_before", 32'(rsp_data), 32'(hd.data));
        @(posedge clock); #1 rsp_ready = 1'b0;
        check("simul_depth", 32'(exp_q.size()), 3);
        if (exp_q.size() != 0) begin
            hd = exp_q[0];
            check("simul_head_advanced", 32'(rsp_data), 32'(hd.data));
        end
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        rsp_ready = 1'b0;
        check("simul_count", 32'(n), 3);

        // Random commands with random backpressure
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() >= 3) rsp_ready = 1'b1;
            else rsp_ready = 1'($urandom_range(0, 1));
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1 rsp_ready = 1'($urandom_range(0, 1));
            end
        end
        rsp_ready = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || rsp_valid || busy) && g < 100) begin
            @(posedge clock); #1;
            g++;
        end
        rsp_ready = 1'b0;
        check("rand_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the ALU operand interface. Accepts operation commands over a valid/ready handshake and drives the ALU's operand and select inputs.
- Holds the ALU inputs stable for a settle window, then samples the ALU result and overflow.
- Executes the two shift opcodes itself, one bit per cycle, because the ALU has no shifter.
- Buffers completed results in a small FIFO that the downstream display logic drains over a second valid/ready handshake.

Parameters:
WIDTH, 8, operand and result width in bits.
SETTLE, 1, cycles the ALU inputs are held before sampling; legal range 1 to 15.
RSP_DEPTH, 4, result FIFO depth; must be a power of two, minimum 2.

Ports:
clock  input  1  single system clock, rising edge.
clear_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted on a cycle where cmd_valid and cmd_ready are both high.
cmd_op  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shift left, 111 shift right.
cmd_a  input  WIDTH  operand A.
cmd_b  input  WIDTH  operand B; bits [2:0] are the shift amount for 110/111.
alu_a  output  WIDTH  registered operand A to the ALU.
alu_b  output  WIDTH  registered operand B to the ALU.
alu_sel  output  3  registered ALU output-mux select.
alu_out  input  WIDTH  ALU result (combinational from alu_a, alu_b, alu_sel).
alu_ovf  input  1  ALU overflow/carry; meaningful only for op 000.
rsp_valid  output  1  FIFO not empty.
rsp_ready  input  1  consumer pops the head entry.
rsp_data  output  WIDTH  head result.
rsp_ovf  output  1  head overflow flag.
rsp_op  output  3  opcode of the head result.
busy  output  1  high when the FSM is not in IDLE.
stat_ops  output  16  completed-result count (see Optional Feature).
stat_ovf  output  16  count of results with overflow set (see Optional Feature).

Behaviour:
Reset:
- Asynchronous on clear_n low; FSM to IDLE and FIFO emptied.
- alu_a=0, alu_b=0, alu_sel=000.
- rsp_valid=0, busy=0, cmd_ready=0 while clear_n is low.
- Reset mid-operation discards the in-flight command and all buffered results.

cmd_ready:
- cmd_ready = (state==IDLE) && (fifo_count < RSP_DEPTH) && clear_n.
- Only one command is in flight, so a push never finds the FIFO full.

FSM states: IDLE, SETTLE, SHIFT.

IDLE:
- On accept at edge k, latch op, a and b; drive alu_a=cmd_a, alu_b=cmd_b, alu_sel=cmd_op.
- If op is 110 or 111: go to SHIFT with cnt=cmd_b[2:0]; shift register sr=cmd_a; sticky flag st=0.
- Otherwise: go to SETTLE with cnt=SETTLE-1.

SETTLE:
- While cnt!=0, decrement cnt.
- At the edge where cnt==0, push {alu_out, ovf, op} and return to IDLE.
- The push occurs at edge k+SETTLE.
- ovf = alu_ovf for op 000; ovf = 0 for ops 001 to 101, because ALU overflow is undefined for those ops.

SHIFT:
- Each edge with cnt!=0: cnt decrements.
  - Shift left: sr = sr<<1 with zero fill, and the old MSB is ORed into st.
  - Shift right: sr = sr>>1 with zero fill, and the old LSB is ORed into st.
- At the edge where cnt==0, push {sr, st, op} and return to IDLE.
- For amount n, the push occurs at edge k+n+1. Amount 0 returns the input unchanged with ovf=0 at edge k+1.
- alu_* stay at their latched values throughout; the ALU output is ignored.

FIFO:
- rsp_valid is high after the push edge; head fields are stable while rsp_valid && !rsp_ready.
- Pop on rsp_valid && rsp_ready.
- Simultaneous push and pop: count is unchanged and order is preserved.
- Pointers wrap modulo RSP_DEPTH; the count register is log2(RSP_DEPTH)+1 bits wide.

busy=0 only in IDLE.

Optional Feature:
DRIVER_STATS_EN
- Defined:
  - stat_ops increments on every FIFO push.
  - stat_ovf increments on pushes with ovf=1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: stat_ops and stat_ovf are tied to 0 and no counter logic is present.
- Ports exist in both builds.

Test Plan:
- Reset mid-shift:
  - Stimulus: accept op 110 with b=7; assert clear_n low 3 cycles later.
  - Required: rsp_valid=0, busy=0, alu_sel=000 immediately; cmd_ready=1 on the first cycle after release; no result ever appears.
- ADD with SETTLE=1:
  - Stimulus: a=8'hFF, b=8'h00, ALU model returns out=8'h00 and ovf=1.
  - Required: push at edge k+1 with rsp_data=8'h00, rsp_ovf=1, rsp_op=000.
  - Rerun with op 001 and ALU ovf=1: rsp_ovf must be 0.
- Shifts:
  - Left: a=8'b1010_0001, b=3 gives rsp_data=8'b0000_1000, rsp_ovf=1 at edge k+4.
  - Right: a=8'b0000_1111, b=2 gives rsp_data=8'b0000_0011, rsp_ovf=1.
  - Right: a=8'hF0, b=0 gives rsp_data=8'hF0, rsp_ovf=0 at edge k+1.
- Backpressure with RSP_DEPTH=4, rsp_ready=0:
  - Stimulus: stream 5 AND commands.
  - Required: cmd_ready=0 after the 4th push; the 5th command is held.
  - Then pulse rsp_ready for one cycle: the 5th is accepted, and results drain in issue order.
- Simultaneous push and pop:
  - Stimulus: FIFO holds 3 entries; rsp_ready=1 on the same edge the 4th result pushes.
  - Required: count stays 3, the head advances, no entry is lost.
- Stats (DRIVER_STATS_EN defined):
  - Stimulus: run the ADD and both shift scenarios above.
  - Required: stat_ops=4, stat_ovf=3.
  - Without the macro, both counters read 0.
